fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, word address loaded into PC after reset.
REQ-002 SHALL have parameter HALT_ON_RESET, default 0, if 1 enter HALT after reset instead of FETCH.
REQ-003 Ports (name direction width meaning): sysclk in 1 system clock; one clock; all logic on rising edge.
REQ-004 sysreset in 1 system reset; asynchronous, active-low.
REQ-005 pc_curr in 32 current PC value (word address).
REQ-006 pc_sel out 1 PC source select: 0 = PC+1, 1 = load pc_in.
REQ-007 pc_in out 32 value loaded into PC when pc_sel=1.
REQ-008 imem_req out 1, imem_addr out 32, imem_ack in 1, imem_rdata in 32: instruction memory request/acknowledge.
REQ-009 redirect_valid in 1, redirect_target in 32: taken branch/jump from execute.
REQ-010 halt_req in 1: ecall/ebreak halt request from decode.
REQ-011 inst_valid out 1, inst_data out 32, inst_pc out 32, dec_ready in 1: valid/ready instruction output to decode.
REQ-012 flush out 1: one-cycle pulse telling downstream to discard in-flight work; halted out 1: core halted.

Function
REQ-013 FSM states SHALL be INIT, FETCH, HOLD, HALT.
REQ-014 INIT: pc_sel=1, pc_in=RESET_VECTOR for exactly one cycle, then FETCH (or HALT if HALT_ON_RESET=1).
REQ-015 PC advances every cycle unless told otherwise, so in every cycle not advancing, controller SHALL drive pc_sel=1, pc_in=pc_curr (hold).
REQ-016 FETCH: imem_req=1, imem_addr=pc_curr; while imem_ack=0 PC held.
REQ-017 FETCH with imem_ack=1: imem_rdata and pc_curr captured into a one-entry output buffer, pc_sel=0 (PC+1) same cycle; inst_valid=1 from next cycle.
REQ-018 Buffer transfer occurs on inst_valid & dec_ready; buffer free in that cycle may accept a new ack (back-to-back throughput 1 instr/cycle with single-cycle memory).
REQ-019 If buffer full and dec_ready=0, state SHALL be HOLD: imem_req=0, PC held, inst_valid/inst_data/inst_pc stable; return to FETCH the cycle after transfer.
REQ-020 redirect_valid=1 in any state except INIT: pc_sel=1, pc_in=redirect_target, buffer invalidated (inst_valid=0 next cycle), flush=1 that cycle, any same-cycle imem_ack data discarded, next state FETCH.
REQ-021 halt_req=1 in FETCH/HOLD (no redirect): next state HALT; imem_req=0; buffered instruction still delivered.
REQ-022 HALT: imem_req=0, PC held, halted=1; exit only via redirect_valid (to FETCH) or reset.
REQ-023 Priority each cycle: reset > redirect_valid > halt_req > imem_ack > dec_ready stall.
REQ-024 PC arithmetic is 32-bit unsigned, PC+1 wraps 32'hFFFF_FFFF -> 0 with no flag.
REQ-025 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-026 sysreset low SHALL asynchronously force state INIT, buffer empty, inst_valid=0, inst_data=0, inst_pc=0, imem_req=0, imem_addr=0, flush=0, halted=0, pc_sel=1, pc_in=RESET_VECTOR.
REQ-027 Reset mid-fetch SHALL abandon the request; no late ack after deassertion is accepted until INIT completes.
REQ-028 First imem_req SHALL assert two cycles after sysreset deasserts.

Structure
REQ-029 FSM state encoding and RESET_VECTOR default SHALL live in the shared core package alongside other RV32I constants.
REQ-030 The one-entry output buffer SHALL be a sub-module fetch_buffer (valid/ready register slice with flush input).
REQ-031 All outputs except pc_sel, pc_in, imem_req, imem_addr, flush SHALL be registered.

Verification
REQ-032 Reset release, imem_ack always 1, dec_ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; inst_pc 0,1,2 with inst_valid continuous.
REQ-033 imem_ack delayed 3 cycles at addr 5 -> pc_sel=1, pc_in=5 held 3 cycles; one instruction with inst_pc=5.
REQ-034 dec_ready=0 for 4 cycles with buffer full -> HOLD, imem_req=0, inst_data stable; resumes at next address after release.
REQ-035 redirect_valid with target 32'h40 coincident with imem_ack -> flush=1, ack data dropped, next imem_addr=32'h40.
REQ-036 halt_req at PC 8 -> halted=1, imem_req=0, PC stays 9; redirect to 32'h10 resumes fetch at 32'h10.
REQ-037 sysreset low mid-fetch at PC 7 -> all outputs at reset values immediately; after release fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared core package: fetch FSM encoding, reset vector default and RV32I constants.
package fetch_controller_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    localparam logic [31:0] RV32I_NOP       = 32'h0000_0013;
    localparam logic [6:0]  RV32I_OP_SYSTEM = 7'b111_0011;
    localparam logic [6:0]  RV32I_OP_JAL    = 7'b110_1111;
    localparam logic [6:0]  RV32I_OP_BRANCH = 7'b110_0011;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fc_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Bundle of PC control, instruction memory, execute/decode feedback and decode output signals.
interface fetch_controller_if;
    logic [31:0] pc_curr;
    logic        pc_sel;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        dec_ready;
    logic        flush;
    logic        halted;

    modport master (
        input  pc_curr, imem_ack, imem_rdata, redirect_valid, redirect_target,
               halt_req, dec_ready,
        output pc_sel, pc_in, imem_req, imem_addr, inst_valid, inst_data,
               inst_pc, flush, halted
    );

    modport slave (
        output pc_curr, imem_ack, imem_rdata, redirect_valid, redirect_target,
               halt_req, dec_ready,
        input  pc_sel, pc_in, imem_req, imem_addr, inst_valid, inst_data,
               inst_pc, flush, halted
    );
endinterface

// File: rtl/fetch_buffer.sv
// One-entry valid/ready register slice holding a fetched instruction and its PC.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    input  logic [31:0] i_pc,
    output logic        o_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic [31:0] o_pc,
    input  logic        i_ready
);
    logic        r_valid;
    logic [31:0] r_data;
    logic [31:0] r_pc;

    // Free when empty or when the current entry leaves this cycle.
    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: drives PC select, instruction memory requests and a one-entry decode buffer.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = RESET_VECTOR_DEFAULT,
    parameter bit          HALT_ON_RESET = 1'b0
) (
    input  logic          sysclk,
    input  logic          sysreset,
    fetch_controller_if.master bus
);
    fc_state_e   r_state;
    fc_state_e   w_state_next;
    logic        r_halted;
    logic        w_req;
    logic        w_pc_sel;
    logic [31:0] w_pc_in;
    logic        w_flush;
    logic        w_redirect;
    logic        w_load;
    logic        w_buf_ready;

    // Redirects are ignored while the reset vector is being loaded.
    assign w_redirect = bus.redirect_valid && (r_state != ST_INIT);
    assign w_load     = w_req && bus.imem_ack && !w_redirect;

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            r_state  <= ST_INIT;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_halted <= (w_state_next == ST_HALT);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_pc_sel     = 1'b1;
        w_pc_in      = bus.pc_curr;
        w_flush      = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_pc_in      = RESET_VECTOR;
                w_state_next = HALT_ON_RESET ? ST_HALT : ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.halt_req) begin
                    w_state_next = ST_HALT;
                end else if (!w_buf_ready) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_req = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.halt_req) begin
                    w_state_next = ST_HALT;
                end else if (w_buf_ready) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase

        if (w_redirect) begin
            w_pc_in      = bus.redirect_target;
            w_flush      = 1'b1;
            w_state_next = ST_FETCH;
        end else if (w_load) begin
            w_pc_sel = 1'b0;
        end
    end

    fetch_buffer u_buffer (
        .clk     (sysclk),
        .rst_n   (sysreset),
        .i_flush (w_redirect),
        .i_valid (w_load),
        .i_data  (bus.imem_rdata),
        .i_pc    (bus.pc_curr),
        .o_ready (w_buf_ready),
        .o_valid (bus.inst_valid),
        .o_data  (bus.inst_data),
        .o_pc    (bus.inst_pc),
        .i_ready (bus.dec_ready)
    );

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = w_req ? bus.pc_curr : '0;
    assign bus.pc_sel    = w_pc_sel;
    assign bus.pc_in     = w_pc_in;
    assign bus.flush     = w_flush;
    assign bus.halted    = r_halted;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized bench for fetch_controller with an external PC register and a hashed instruction memory.
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    int          checks;
    int          errors;
    int          deliveries;
    logic [31:0] exp_pc;

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_VECTOR  (32'h0000_0000),
        .HALT_ON_RESET (1'b0)
    ) dut (
        .sysclk   (clk),
        .sysreset (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Environment PC register: advances by one unless the controller loads a value.
    always @(posedge clk) begin
        if (bus.pc_sel) pc <= bus.pc_in;
        else            pc <= pc + 32'd1;
    end

    assign bus.pc_curr    = pc;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic ack, input logic rdy, input logic rv,
                       input logic [31:0] tgt, input logic hl);
        bus.imem_ack        = ack;
        bus.dec_ready       = rdy;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.halt_req        = hl;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_req"},    bus.imem_req,   1'b0);
        chk ({tag, "_addr"},   bus.imem_addr,  32'h0);
        chk1({tag, "_pcsel"},  bus.pc_sel,     1'b1);
        chk ({tag, "_pcin"},   bus.pc_in,      32'h0);
        chk1({tag, "_flush"},  bus.flush,      1'b0);
        chk1({tag, "_halted"}, bus.halted,     1'b0);
        chk1({tag, "_valid"},  bus.inst_valid, 1'b0);
        chk ({tag, "_data"},   bus.inst_data,  32'h0);
        chk ({tag, "_ipc"},    bus.inst_pc,    32'h0);
    endtask

    initial begin
        logic        a, r, rv, hl;
        logic [31:0] tgt;
        checks = 0;
        errors = 0;
        deliveries = 0;
        rst_n = 1'b0;
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("reset");

        // Streaming fetch after reset release
        rst_n = 1'b1;
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("init_req", bus.imem_req, 1'b0);
        chk1("init_pcsel", bus.pc_sel, 1'b1);
        chk ("init_pcin", bus.pc_in, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("stream_req", bus.imem_req, 1'b1);
            chk ("stream_addr", bus.imem_addr, 32'(i));
            chk1("stream_pcsel", bus.pc_sel, 1'b0);
            if (i > 0) begin
                chk1("stream_valid", bus.inst_valid, 1'b1);
                chk ("stream_ipc", bus.inst_pc, 32'(i - 1));
                chk ("stream_data", bus.inst_data, mem_word(32'(i - 1)));
            end
            @(negedge clk);
        end
        #1 chk("stream_addr4", bus.imem_addr, 32'h4);
        @(negedge clk);

        // Ack delayed three cycles at address 5
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("wait_req", bus.imem_req, 1'b1);
            chk ("wait_addr", bus.imem_addr, 32'h5);
            chk1("wait_pcsel", bus.pc_sel, 1'b1);
            chk ("wait_pcin", bus.pc_in, 32'h5);
            @(negedge clk);
        end
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1 chk1("wait_ack_pcsel", bus.pc_sel, 1'b0);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("wait_valid", bus.inst_valid, 1'b1);
        chk ("wait_ipc", bus.inst_pc, 32'h5);
        chk ("wait_data", bus.inst_data, mem_word(32'h5));
        @(negedge clk);

        // Decode stall with a full buffer
        drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("single_valid", bus.inst_valid, 1'b0);
        chk ("stall_addr", bus.imem_addr, 32'h6);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("stall_req", bus.imem_req, 1'b0);
            chk1("stall_valid", bus.inst_valid, 1'b1);
            chk ("stall_ipc", bus.inst_pc, 32'h6);
            chk ("stall_data", bus.inst_data, mem_word(32'h6));
            chk ("stall_pcin", bus.pc_in, 32'h7);
            @(negedge clk);
        end
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1 chk1("release_req", bus.imem_req, 1'b0);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("resume_req", bus.imem_req, 1'b1);
        chk ("resume_addr", bus.imem_addr, 32'h7);
        @(negedge clk);

        // Redirect coincident with an ack
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1 chk("pre_redirect_addr", bus.imem_addr, 32'h7);
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
        #1;
        chk1("redirect_flush", bus.flush, 1'b1);
        chk1("redirect_pcsel", bus.pc_sel, 1'b1);
        chk ("redirect_pcin", bus.pc_in, 32'h40);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("redirect_drop_valid", bus.inst_valid, 1'b0);
        chk1("redirect_flush_end", bus.flush, 1'b0);
        chk ("redirect_addr", bus.imem_addr, 32'h40);
        @(negedge clk);

        // Halt raised while PC has moved past 8, then resume via redirect
        drv(1'b0, 1'b1, 1'b1, 32'h8, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1 chk("halt_fetch_addr", bus.imem_addr, 32'h8);
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        chk1("halt_req_blocks", bus.imem_req, 1'b0);
        chk ("halt_pcin", bus.pc_in, 32'h9);
        chk1("halt_deliver_valid", bus.inst_valid, 1'b1);
        chk ("halt_deliver_ipc", bus.inst_pc, 32'h8);
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk1("halted", bus.halted, 1'b1);
            chk1("halted_req", bus.imem_req, 1'b0);
            chk ("halted_pc", pc, 32'h9);
            @(negedge clk);
        end
        drv(1'b0, 1'b1, 1'b1, 32'h10, 1'b0);
        #1 chk("unhalt_pcin", bus.pc_in, 32'h10);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("unhalt_halted", bus.halted, 1'b0);
        chk ("unhalt_addr", bus.imem_addr, 32'h10);
        @(negedge clk);

        // PC wrap-around
        drv(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1 chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFF);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("wrap_req", bus.imem_req, 1'b1);
        chk ("wrap_addr_zero", bus.imem_addr, 32'h0);
        chk ("wrap_ipc", bus.inst_pc, 32'hFFFF_FFFF);
        @(negedge clk);

        // Reset asserted mid-fetch at PC 7
        drv(1'b0, 1'b1, 1'b1, 32'h6, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk ("midfetch_addr", bus.imem_addr, 32'h7);
        chk1("midfetch_valid", bus.inst_valid, 1'b1);
        rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1 chk1("late_ack_req", bus.imem_req, 1'b0);
        @(negedge clk);
        #1;
        chk1("restart_req", bus.imem_req, 1'b1);
        chk ("restart_addr", bus.imem_addr, 32'h0);
        @(negedge clk);

        // Randomized traffic against an in-order delivery scoreboard
        drv(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
        exp_pc = 32'h100;
        @(negedge clk);
        for (int n = 0; n < 600; n++) begin
            a   = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            hl  = ($urandom_range(0, 49) == 0);
            tgt = $urandom();
            drv(a, r, rv, tgt, hl);
            #1;
            if (bus.imem_req) chk("rnd_addr", bus.imem_addr, pc);
            if (bus.halted)   chk1("rnd_halted_req", bus.imem_req, 1'b0);
            if (rv) begin
                chk1("rnd_flush", bus.flush, 1'b1);
                chk ("rnd_pcin", bus.pc_in, tgt);
                exp_pc = tgt;
            end else if (bus.inst_valid && r) begin
                chk("rnd_ipc", bus.inst_pc, exp_pc);
                chk("rnd_data", bus.inst_data, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd1;
                deliveries++;
            end
            @(negedge clk);
        end
        chk1("rnd_progress", deliveries > 50, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
